// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction reader and a data reader/writer.
// Build option: define ARB_ROUND_ROBIN_EN for alternating contention grants (default: data always wins).
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // instruction requester
  input  logic             inst_read,
  input  logic [WIDTH-1:0] inst_addr,
  output logic             inst_resp,
  output logic [WIDTH-1:0] inst_rdata,
  // data requester
  input  logic             data_read,
  input  logic             data_write,
  input  logic [3:0]       data_mbe,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] data_wdata,
  output logic             data_resp,
  output logic [WIDTH-1:0] data_rdata,
  // shared memory port
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       mem_mbe,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_reg;
  logic   data_req;
  logic   grant_inst;

  assign data_req = data_read | data_write;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic LAST_INST = 1'b0;
  localparam logic LAST_DATA = 1'b1;

  logic last_grant_reg;

  // On contention the instruction side wins only if data had the previous grant.
  assign grant_inst = inst_read & (~data_req | (last_grant_reg == LAST_DATA));
`else
  assign grant_inst = inst_read & ~data_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_reg <= LAST_DATA;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_inst) begin
            state_reg      <= INST;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_reg <= LAST_INST;
`endif
          end else if (data_req) begin
            state_reg      <= DATA;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_reg <= LAST_DATA;
`endif
          end
        end
        // The grant is held until the memory completes, even if the requester lets go.
        INST, DATA: begin
          if (mem_resp) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_mbe   = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      INST: begin
        mem_read = 1'b1;
        mem_addr = inst_addr;
      end
      DATA: begin
        // Read and write together resolve to a write.
        mem_read  = data_read & ~data_write;
        mem_write = data_write;
        mem_mbe   = data_mbe;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  assign inst_resp  = mem_resp & (state_reg == INST);
  assign data_resp  = mem_resp & (state_reg == DATA);
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences for
// reset/idle corners, and random transactions checked against a grant-order model.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;
  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_INST = 2'd1;
  localparam logic [1:0] G_DATA = 2'd2;

  logic             clk = 1'b0;
  logic             rst;
  logic             inst_read;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_resp;
  logic [WIDTH-1:0] inst_rdata;
  logic             data_read;
  logic             data_write;
  logic [3:0]       data_mbe;
  logic [WIDTH-1:0] data_addr;
  logic [WIDTH-1:0] data_wdata;
  logic             data_resp;
  logic [WIDTH-1:0] data_rdata;
  logic             mem_read;
  logic             mem_write;
  logic [3:0]       mem_mbe;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;

  int tests  = 0;
  int failed = 0;
  logic [1:0] model_last = G_DATA;

  mem_port_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_read  (inst_read),
    .inst_addr  (inst_addr),
    .inst_resp  (inst_resp),
    .inst_rdata (inst_rdata),
    .data_read  (data_read),
    .data_write (data_write),
    .data_mbe   (data_mbe),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_resp  (data_resp),
    .data_rdata (data_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_mbe    (mem_mbe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ir;
    bit          dr;
    bit          dw;
    bit          rep;
    logic [3:0]  mbe;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    logic [5:0]  seq;   // expected grant order, first grant in [1:0]
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mkv(bit ir, bit dr, bit dw, bit rep, logic [3:0] mbe,
                               logic [31:0] ia, logic [31:0] da, logic [31:0] wd,
                               logic [31:0] rd, int lat, logic [5:0] seq);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rep = rep; v.mbe = mbe;
    v.ia = ia; v.da = da; v.wd = wd; v.rd = rd; v.lat = lat; v.seq = seq;
    return v;
  endfunction

  // Grant order derived from the arbitration rules: a lone requester wins, contention
  // goes to data (or alternates with the build option); the winner re-requests once if rep.
  function automatic logic [5:0] model_plan(bit ir, bit dreq, bit rep, logic [1:0] last);
    logic [5:0] s;
    bit pi;
    bit pd;
    logic [1:0] w;
    s = '0; pi = ir; pd = dreq;
    for (int k = 0; k < 3; k++) begin
      if (!pi && !pd) break;
      if (pi && pd) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (last == G_DATA) ? G_INST : G_DATA;
`else
        w = G_DATA;
`endif
      end else begin
        w = pi ? G_INST : G_DATA;
      end
      s[2*k +: 2] = w;
      last = w;
      if (!(rep && k == 0)) begin
        if (w == G_INST) pi = 1'b0;
        else pd = 1'b0;
      end
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "/idle_read"},  32'(mem_read),  32'd0);
    chk({tag, "/idle_write"}, 32'(mem_write), 32'd0);
    chk({tag, "/idle_mbe"},   32'(mem_mbe),   32'd0);
    chk({tag, "/idle_addr"},  mem_addr,       32'd0);
    chk({tag, "/idle_wdata"}, mem_wdata,      32'd0);
  endtask

  task automatic check_grant(input string tag, input logic [1:0] g);
    if (g == G_INST) begin
      chk({tag, "/inst_read"},  32'(mem_read),  32'd1);
      chk({tag, "/inst_write"}, 32'(mem_write), 32'd0);
      chk({tag, "/inst_mbe"},   32'(mem_mbe),   32'd0);
      chk({tag, "/inst_addr"},  mem_addr,       inst_addr);
      chk({tag, "/inst_wdata"}, mem_wdata,      32'd0);
    end else begin
      chk({tag, "/data_read"},  32'(mem_read),  32'(data_read & ~data_write));
      chk({tag, "/data_write"}, 32'(mem_write), 32'(data_write));
      chk({tag, "/data_mbe"},   32'(mem_mbe),   32'(data_mbe));
      chk({tag, "/data_addr"},  mem_addr,       data_addr);
      chk({tag, "/data_wdata"}, mem_wdata,      data_wdata);
    end
  endtask

  // Requests are raised in an idle cycle; each grant holds for lat+1 cycles, the last of
  // which carries mem_resp, followed by one mandatory idle cycle.
  task automatic run_txn(input string tag, input vec_t v);
    logic [1:0] g;
    @(negedge clk);
    inst_read = v.ir; inst_addr = v.ia;
    data_read = v.dr; data_write = v.dw; data_mbe = v.mbe;
    data_addr = v.da; data_wdata = v.wd;
    #1 check_idle({tag, "/start"});
    for (int k = 0; k < 3; k++) begin
      g = v.seq[2*k +: 2];
      if (g == G_NONE) break;
      for (int c = 0; c <= v.lat; c++) begin
        @(negedge clk);
        mem_resp  = (c == v.lat);
        mem_rdata = v.rd + 32'(k);
        #1;
        check_grant($sformatf("%s/g%0d", tag, k), g);
        chk($sformatf("%s/g%0d/inst_resp", tag, k), 32'(inst_resp),
            32'(c == v.lat && g == G_INST));
        chk($sformatf("%s/g%0d/data_resp", tag, k), 32'(data_resp),
            32'(c == v.lat && g == G_DATA));
        if (c == v.lat) begin
          chk($sformatf("%s/g%0d/inst_rdata", tag, k), inst_rdata, v.rd + 32'(k));
          chk($sformatf("%s/g%0d/data_rdata", tag, k), data_rdata, v.rd + 32'(k));
        end
      end
      model_last = g;
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = '0;
      if (!(v.rep && k == 0)) begin
        if (g == G_INST) inst_read = 1'b0;
        else begin data_read = 1'b0; data_write = 1'b0; end
      end
      #1 check_idle($sformatf("%s/g%0d/after", tag, k));
      chk($sformatf("%s/g%0d/after_resp", tag, k), 32'({inst_resp, data_resp}), 32'd0);
    end
    inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    $display("[TB] txn %s: ir=%0d dr=%0d dw=%0d rep=%0d lat=%0d grants=%b",
             tag, v.ir, v.dr, v.dw, v.rep, v.lat, v.seq);
  endtask

  initial begin
    vec_t rv;
    logic [5:0] seq_cont_rep;
    logic [5:0] seq_cont_wr;
`ifdef ARB_ROUND_ROBIN_EN
    seq_cont_rep = {G_INST, G_DATA, G_INST};
    seq_cont_wr  = {G_NONE, G_DATA, G_INST};
`else
    seq_cont_rep = {G_INST, G_DATA, G_DATA};
    seq_cont_wr  = {G_NONE, G_INST, G_DATA};
`endif
    vecs[0] = mkv(1, 0, 0, 0, 4'h0, 32'h60,  32'h0,    32'h0,        32'h13,       2, {G_NONE, G_NONE, G_INST});
    vecs[1] = mkv(0, 0, 1, 0, 4'h3, 32'h0,   32'h100,  32'hDEADBEEF, 32'h0,        1, {G_NONE, G_NONE, G_DATA});
    vecs[2] = mkv(1, 1, 0, 1, 4'h0, 32'h80,  32'h180,  32'h0,        32'hA5A50000, 0, seq_cont_rep);
    vecs[3] = mkv(0, 1, 1, 0, 4'hF, 32'h0,   32'h44,   32'h12345678, 32'h0,        3, {G_NONE, G_NONE, G_DATA});
    vecs[4] = mkv(0, 1, 0, 0, 4'hA, 32'h0,   32'h1000, 32'h55AA55AA, 32'hCAFEF00D, 1, {G_NONE, G_NONE, G_DATA});
    vecs[5] = mkv(1, 0, 1, 0, 4'h5, 32'h2C0, 32'h3C0,  32'h0BADF00D, 32'h77,       0, seq_cont_wr);
    vecs[6] = mkv(0, 0, 0, 0, 4'h0, 32'h0,   32'h0,    32'h0,        32'h0,        0, {G_NONE, G_NONE, G_NONE});

    rst = 1'b1;
    inst_read = 0; inst_addr = '0;
    data_read = 0; data_write = 0; data_mbe = '0; data_addr = '0; data_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1 check_idle("reset");
    chk("reset/resp", 32'({inst_resp, data_resp}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 check_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset during a data grant abandons it; a late mem_resp is then ignored.
    @(negedge clk);
    data_read = 1'b1; data_addr = 32'h200; data_mbe = 4'hC;
    #1 check_idle("rst_mid/start");
    @(negedge clk);
    #1 chk("rst_mid/granted", 32'(mem_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1 check_idle("rst_mid/in_reset");
    rst = 1'b0; data_read = 1'b0;
    model_last = G_DATA;
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 32'h99;
    #1 chk("rst_mid/late_data_resp", 32'(data_resp), 32'd0);
    chk("rst_mid/late_inst_resp", 32'(inst_resp), 32'd0);
    check_idle("rst_mid/late");
    @(negedge clk);
    mem_resp = 1'b0;
    #1 check_idle("rst_mid/after");
    $display("[TB] txn rst_mid: reset during data grant, late mem_resp ignored");

    // Stray mem_resp while idle with no requests.
    @(negedge clk);
    mem_resp = 1'b1;
    #1 chk("idle_resp/inst_resp", 32'(inst_resp), 32'd0);
    chk("idle_resp/data_resp", 32'(data_resp), 32'd0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1 check_idle("idle_resp/after");
    $display("[TB] txn idle_resp: stray mem_resp in idle");

    for (int i = 0; i < 40; i++) begin
      rv.ir  = 1'($urandom_range(0, 1));
      rv.dr  = 1'($urandom_range(0, 1));
      rv.dw  = 1'($urandom_range(0, 1));
      rv.rep = 1'($urandom_range(0, 1));
      rv.mbe = 4'($urandom);
      rv.ia  = $urandom;
      rv.da  = $urandom;
      rv.wd  = $urandom;
      rv.rd  = $urandom;
      rv.lat = int'($urandom_range(0, 3));
      rv.seq = model_plan(rv.ir, rv.dr | rv.dw, rv.rep, model_last);
      run_txn($sformatf("rand%0d", i), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, width of address and data buses in bits.
REQ-002 Ports `clk` and `rst`: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset input.
REQ-003 Instruction requester ports:
- `inst_read`  in  1  instruction read request; held high until `inst_resp`.
- `inst_addr`  in  WIDTH  instruction address.
- `inst_resp`  out  1  instruction transaction complete.
- `inst_rdata`  out  WIDTH  instruction read data.
REQ-004 Data requester ports:
- `data_read`  in  1  data read request; held high until `data_resp`.
- `data_write`  in  1  data write request; held high until `data_resp`.
- `data_mbe`  in  4  byte enables for writes.
- `data_addr`  in  WIDTH  data address.
- `data_wdata`  in  WIDTH  write data.
- `data_resp`  out  1  data transaction complete.
- `data_rdata`  out  WIDTH  data read data.
REQ-005 Shared memory port:
- `mem_read`  out  1  read strobe.
- `mem_write`  out  1  write strobe.
- `mem_mbe`  out  4  byte enables.
- `mem_addr`  out  WIDTH  address.
- `mem_wdata`  out  WIDTH  write data.
- `mem_resp`  in  1  memory completion, one-cycle pulse.
- `mem_rdata`  in  WIDTH  read data, valid with `mem_resp`.

Function
REQ-006 FSM states: IDLE, INST, DATA; register state and the `last_grant` bit only.
REQ-007 Transitions from IDLE:
- data request only (`data_read|data_write`) -> DATA.
- `inst_read` only -> INST.
- both pending -> winner per REQ-014; neither -> stay IDLE.
REQ-008 INST/DATA -> IDLE on the cycle after `mem_resp`=1; otherwise hold state.
REQ-009 In IDLE: `mem_read`=`mem_write`=0; `mem_mbe`, `mem_addr`, `mem_wdata`=0.
REQ-010 In INST:
- `mem_read`=1, `mem_write`=0, `mem_addr`=`inst_addr`, `mem_mbe`=4'b0000, `mem_wdata`=0.
REQ-011 In DATA:
- `mem_read`=`data_read` & ~`data_write`, `mem_write`=`data_write`.
- `mem_addr`/`mem_mbe`/`mem_wdata` driven from the data port.
- `data_read` and `data_write` both high is treated as a write.
REQ-012 Responses:
- `inst_resp`=`mem_resp` & (state==INST); `data_resp`=`mem_resp` & (state==DATA); combinational, same cycle as `mem_resp`.
- `inst_rdata`=`data_rdata`=`mem_rdata` unconditionally.
REQ-013 Latency: request first seen in IDLE at cycle N -> memory strobe at N+1; one mandatory IDLE cycle after each completion.
- Back-to-back transactions therefore issue no faster than one every (memory latency + 2) cycles.
REQ-014 Contention (both pending in IDLE): winner depends on configuration (REQ-019); the winner is recorded in `last_grant` on the grant edge.
REQ-015 `mem_resp` received in IDLE is ignored and produces no `*_resp`.
REQ-016 A requester dropping its request before its `*_resp` is a protocol violation; the arbiter keeps the grant until `mem_resp`.

Reset
REQ-017 On `rst`=1 at a clock edge: state<=IDLE; `last_grant`<=DATA; all `mem_*` strobes 0 on the next cycle.
REQ-018 Reset mid-transaction abandons the grant; a late `mem_resp` after reset is ignored per REQ-015.

Configuration
REQ-019 Macro `ARB_ROUND_ROBIN_EN`:
- Defined: on contention, grant the requester not in `last_grant`; the first contention after reset grants INST.
- Undefined: on contention, DATA always wins and `last_grant` is unused (tie-off permitted).

Verification
REQ-020 Cycle 2: `inst_read`=1, `inst_addr`=0x60 -> cycle 3 `mem_read`=1, `mem_addr`=0x60; `mem_resp`=1, `mem_rdata`=0x00000013 at cycle 5 -> `inst_resp`=1, `inst_rdata`=0x00000013 at cycle 5; IDLE at cycle 6.
REQ-021 `data_write`=1, `data_addr`=0x100, `data_mbe`=4'b0011, `data_wdata`=0xDEADBEEF:
- `mem_write`=1 with identical fields next cycle.
- `inst_resp` stays 0 throughout.
REQ-022 Both `inst_read` and `data_read` high in IDLE:
- Macro undefined: DATA granted twice in a row.
- Macro defined: INST granted first, then DATA.
REQ-023 `rst`=1 while in DATA before `mem_resp` -> next cycle IDLE, all strobes 0; `mem_resp` pulse one cycle later -> `data_resp`=0.
REQ-024 `mem_resp`=1 while in IDLE with no request -> `inst_resp`=`data_resp`=0; state stays IDLE.
